audio_filter_axil_regs: RTL and testbench
=========================================

# audio_filter_axil_regs

AXI4-Lite slave register file for the audio filter block's S00_AXI control port. It is the responder for the master VIP's AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic. It holds four 32-bit read/write configuration registers at 0x00–0x0C, which feed the filter datapath, and issues a one-cycle update pulse per register write.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width (16 word slots; slots 0–3 implemented).

Ports:
- ACLK  in  1  sole clock; all logic rising-edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  6  write address; bits [1:0] ignored.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  6  read address; bits [1:0] ignored.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- slv_reg0..slv_reg3  out  32 each  register contents to the datapath.
- reg_wr_pulse  out  4  bit n high for exactly one cycle after any write to slot n.

## Operation
- Write FSM states:
  - WR_IDLE: AWREADY=1 until AW is captured. WREADY=1 until W is captured. AW and W are accepted in either order or in the same cycle; each is latched independently.
  - Once both AW and W are latched, the write commits on that edge: register bytes update where WSTRB=1, and the FSM moves to WR_RESP.
  - WR_RESP: BVALID=1, AWREADY=0, WREADY=0. BVALID holds until BREADY=1, then the FSM returns to WR_IDLE.
- Read FSM states:
  - RD_IDLE: ARREADY=1. On an AR handshake, RDATA/RRESP are registered from the addressed slot on that edge, and the FSM moves to RD_DATA.
  - RD_DATA: RVALID=1, ARREADY=0. RDATA/RRESP are held stable until RREADY=1, then the FSM returns to RD_IDLE.
- The read and write channels are fully independent; one outstanding transaction per direction.
- Write commit and AR handshake on the same edge to the same slot: the read returns the pre-write value.
- Word index = ADDR[5:2]. Index 0–3 selects slv_reg0–3.
- Unmapped index 4–15: behaviour set by Configuration. Unmapped writes never modify any register and never pulse reg_wr_pulse.
- reg_wr_pulse[n] asserts in the cycle after commit (concurrent with the first BVALID cycle) for mapped writes, including WSTRB=0.

## Timing
- Reset values, all asynchronous on ARESETN=0:
  - AWREADY=0, WREADY=0, ARREADY=0 while reset is asserted; each goes to 1 on the first edge after release.
  - BVALID=0, RVALID=0, BRESP=00, RRESP=00, RDATA=0.
  - slv_reg0..3 = 0, reg_wr_pulse = 0.
- Write latency: with AW and W together at edge k, BVALID=1 from cycle k+1. Maximum rate is one write per 2 cycles with BREADY tied high.
- Read latency: with an AR handshake at edge k, RVALID=1 from cycle k+1. Maximum rate is one read per 2 cycles with RREADY tied high.
- BVALID and RVALID never drop without their READY. Output values are held under backpressure.
- Reset mid-transaction: the in-flight transaction is discarded, registers clear, and no response is issued after reset.

## Configuration
- Macro AUDIO_FILTER_AXIL_DECERR_EN.
- Defined: an unmapped read returns RDATA=0, RRESP=SLVERR (10); an unmapped write returns BRESP=SLVERR (10).
- Undefined: unmapped slots are read-as-zero / write-ignored with OKAY (00).
- Mapped slots always return OKAY.

## Test plan
- Reset, then write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4, all BRESP/RRESP=00, reg_wr_pulse = 0001,0010,0100,1000 in turn.
- W presented 3 cycles before AW (addr 0x4, data 0xDEADBEEF) -> WREADY drops after the W handshake, commit only on the AW handshake, slv_reg1=0xDEADBEEF, BVALID the next cycle.
- Write 0xFFFFFFFF to 0x8, then 0x00000000 with WSTRB=0101 -> slv_reg2=0xFF00FF00.
- Hold BREADY=0 and RREADY=0 for 10 cycles -> BVALID/RVALID and RDATA stable, AWREADY/ARREADY=0, a second AW is not accepted until the B handshake.
- Read of 0x20 and write of 0x3C -> with the macro defined: RRESP=BRESP=10, RDATA=0; with it undefined: both 00; in both builds registers and reg_wr_pulse are unchanged.
- Pull ARESETN low while BVALID=1 and slv_reg0=0x5 -> BVALID=0 and slv_reg0=0 immediately, with no response after release.

Source files
------------

// File: rtl/audio_filter_axil_regs.sv
// AXI4-Lite slave register file for the audio filter control port: four 32-bit R/W registers
// with per-register write pulses. Define AUDIO_FILTER_AXIL_DECERR_EN to answer unmapped slots with SLVERR.
module audio_filter_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
   output logic [3:0]                        reg_wr_pulse
);

   localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned NumRegs  = 4;
   localparam int unsigned IdxW     = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0]  RespOkay = 2'b00;
`ifdef AUDIO_FILTER_AXIL_DECERR_EN
   localparam logic [1:0]  RespUnmapped = 2'b10;
`else
   localparam logic [1:0]  RespUnmapped = 2'b00;
`endif

   typedef enum logic {WrIdle, WrResp} wr_state_e;
   typedef enum logic {RdIdle, RdData} rd_state_e;

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic                          rdy_en_q;
   logic                          aw_done_q, w_done_q;
   logic [IdxW-1:0]               aw_idx_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
   logic [NumBytes-1:0]           wstrb_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg_q [NumRegs];
   logic [1:0]                    bresp_q, rresp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [3:0]                    pulse_q, pulse_d;

   logic                          aw_ready, w_ready, b_valid, ar_ready, r_valid;
   logic                          aw_hs, w_hs, ar_hs, wr_commit;
   logic [IdxW-1:0]               wr_idx, rd_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
   logic [NumBytes-1:0]           wr_strb;
   logic                          wr_mapped, rd_mapped;

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Holds all READY low until the first edge after reset release.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdy_en_q <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
      end
   end

   // ---------------- write channel ----------------
   assign aw_hs     = S_AXI_AWVALID & aw_ready;
   assign w_hs      = S_AXI_WVALID & w_ready;
   assign wr_commit = (wr_state_q == WrIdle) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
   assign wr_idx    = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : aw_idx_q;
   assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
   assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
   assign wr_mapped = 32'(wr_idx) < NumRegs;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q <= WrIdle;
      end else begin
         wr_state_q <= wr_state_d;
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      unique case (wr_state_q)
         WrIdle:  if (wr_commit) wr_state_d = WrResp;
         WrResp:  if (S_AXI_BREADY) wr_state_d = WrIdle;
         default: wr_state_d = WrIdle;
      endcase
   end

   always_comb begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      unique case (wr_state_q)
         WrIdle: begin
            aw_ready = rdy_en_q & ~aw_done_q;
            w_ready  = rdy_en_q & ~w_done_q;
         end
         WrResp:  b_valid = 1'b1;
         default: b_valid = 1'b0;
      endcase
   end

   // AW and W are latched independently so they may arrive in any order.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else if (wr_commit) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_done_q <= 1'b1;
            aw_idx_q  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         end
         if (w_hs) begin
            w_done_q <= 1'b1;
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int r = 0; r < NumRegs; r++) begin
            slv_reg_q[r] <= '0;
         end
      end else if (wr_commit && wr_mapped) begin
         for (int r = 0; r < NumRegs; r++) begin
            for (int b = 0; b < NumBytes; b++) begin
               if (wr_idx == IdxW'(r) && wr_strb[b]) begin
                  slv_reg_q[r][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      pulse_d = '0;
      if (wr_commit && wr_mapped) begin
         pulse_d[wr_idx[1:0]] = 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bresp_q <= RespOkay;
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
         if (wr_commit) begin
            bresp_q <= wr_mapped ? RespOkay : RespUnmapped;
         end
      end
   end

   // ---------------- read channel ----------------
   assign ar_hs     = S_AXI_ARVALID & ar_ready;
   assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign rd_mapped = 32'(rd_idx) < NumRegs;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state_q <= RdIdle;
      end else begin
         rd_state_q <= rd_state_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RdIdle:  if (ar_hs) rd_state_d = RdData;
         RdData:  if (S_AXI_RREADY) rd_state_d = RdIdle;
         default: rd_state_d = RdIdle;
      endcase
   end

   always_comb begin
      ar_ready = 1'b0;
      r_valid  = 1'b0;
      unique case (rd_state_q)
         RdIdle:  ar_ready = rdy_en_q;
         RdData:  r_valid  = 1'b1;
         default: r_valid  = 1'b0;
      endcase
   end

   // Sampling slv_reg_q here yields the pre-write value on a same-edge commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdata_q <= '0;
         rresp_q <= RespOkay;
      end else if (ar_hs) begin
         rdata_q <= rd_mapped ? slv_reg_q[rd_idx[1:0]] : '0;
         rresp_q <= rd_mapped ? RespOkay : RespUnmapped;
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_WREADY  = w_ready;
   assign S_AXI_BVALID  = b_valid;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RVALID  = r_valid;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign slv_reg0      = slv_reg_q[0];
   assign slv_reg1      = slv_reg_q[1];
   assign slv_reg2      = slv_reg_q[2];
   assign slv_reg3      = slv_reg_q[3];
   assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_audio_filter_axil_regs.sv
// Scoreboard bench for audio_filter_axil_regs: stimulus pushes expectations, a negedge monitor
// pops and compares on every B/R handshake. Honours AUDIO_FILTER_AXIL_DECERR_EN.
module tb_audio_filter_axil_regs;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [5:0]  S_AXI_AWADDR = '0;
   logic [2:0]  S_AXI_AWPROT = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b1;
   logic [5:0]  S_AXI_ARADDR = '0;
   logic [2:0]  S_AXI_ARPROT = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b1;
   logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
   logic [3:0]  reg_wr_pulse;

   always #5 ACLK = ~ACLK;

   audio_filter_axil_regs dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
      .reg_wr_pulse(reg_wr_pulse)
   );

`ifdef AUDIO_FILTER_AXIL_DECERR_EN
   localparam logic [1:0] UnmapResp = 2'b10;
`else
   localparam logic [1:0] UnmapResp = 2'b00;
`endif

   typedef struct packed {
      logic [1:0]   resp;
      logic [127:0] regs;
      logic [3:0]   pulse;
   } b_exp_t;
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   b_exp_t      b_q[$];
   r_exp_t      r_q[$];
   logic [31:0] model [4];
   int          n_checks = 0;
   int          n_pass = 0;
   bit          rand_bp = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: word-addressed array, byte-masked merge.
   task automatic exp_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int unsigned idx = 32'(addr) / 4;
      logic [31:0] mask = '0;
      b_exp_t e;
      for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
      if (idx < 4) begin
         model[idx] = (model[idx] & ~mask) | (data & mask);
         e.resp  = 2'b00;
         e.pulse = 4'(1 << idx);
      end else begin
         e.resp  = UnmapResp;
         e.pulse = 4'b0000;
      end
      e.regs = {model[3], model[2], model[1], model[0]};
      b_q.push_back(e);
   endtask

   task automatic exp_read(input logic [5:0] addr);
      int unsigned idx = 32'(addr) / 4;
      r_exp_t e;
      e.data = (idx < 4) ? model[idx] : 32'h0;
      e.resp = (idx < 4) ? 2'b00 : UnmapResp;
      r_q.push_back(e);
   endtask

   // Waits (bounded) for a condition seen at a negedge: 0 AW,1 W,2 AR,3 B hs,4 R hs.
   task automatic wait_neg(input int which);
      bit seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge ACLK);
         case (which)
            0: seen = S_AXI_AWREADY;
            1: seen = S_AXI_WREADY;
            2: seen = S_AXI_ARREADY;
            3: seen = S_AXI_BVALID && S_AXI_BREADY;
            default: seen = S_AXI_RVALID && S_AXI_RREADY;
         endcase
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL timeout_%0d: got no handshake expected handshake", which);
      end
   endtask

   task automatic drive_write(input logic [5:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int dly_aw, input int dly_w,
                              input bit wait_b);
      fork
         begin
            repeat (dly_aw) begin @(posedge ACLK); #1; end
            S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
            wait_neg(0);
            @(posedge ACLK); #1; S_AXI_AWVALID = 1'b0;
            if (dly_w > dly_aw) begin
               @(negedge ACLK);
               chk("awready_drop", 128'(S_AXI_AWREADY), 128'(0));
               chk("no_early_b_aw", 128'(S_AXI_BVALID), 128'(0));
            end
         end
         begin
            repeat (dly_w) begin @(posedge ACLK); #1; end
            S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
            wait_neg(1);
            @(posedge ACLK); #1; S_AXI_WVALID = 1'b0;
            if (dly_aw > dly_w) begin
               @(negedge ACLK);
               chk("wready_drop", 128'(S_AXI_WREADY), 128'(0));
               chk("no_early_b_w", 128'(S_AXI_BVALID), 128'(0));
            end
         end
      join
      @(negedge ACLK);
      chk("b_latency", 128'(S_AXI_BVALID), 128'(1));
      if (wait_b) begin
         if (!(S_AXI_BVALID && S_AXI_BREADY)) wait_neg(3);
         @(posedge ACLK); #1;
      end
   endtask

   task automatic drive_read(input logic [5:0] addr, input int dly, input bit wait_r);
      repeat (dly) begin @(posedge ACLK); #1; end
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      wait_neg(2);
      @(posedge ACLK); #1; S_AXI_ARVALID = 1'b0;
      @(negedge ACLK);
      chk("r_latency", 128'(S_AXI_RVALID), 128'(1));
      if (wait_r) begin
         if (!(S_AXI_RVALID && S_AXI_RREADY)) wait_neg(4);
         @(posedge ACLK); #1;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && (b_q.size() != 0 || r_q.size() != 0); n++) @(negedge ACLK);
      chk("queues_drained", 128'(b_q.size() + r_q.size()), 128'(0));
      @(posedge ACLK); #1;
   endtask

   initial begin
      forever begin
         @(posedge ACLK); #1;
         if (rand_bp) begin
            S_AXI_BREADY = 1'($urandom_range(0, 1));
            S_AXI_RREADY = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: scoreboard pops, pulse timing, hold-under-backpressure.
   logic        prev_bv = 1'b0, prev_br = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
   logic [1:0]  prev_bresp = '0, prev_rresp = '0;
   logic [31:0] prev_rdata = '0;
   always @(negedge ACLK) begin
      b_exp_t be;
      r_exp_t re;
      logic [3:0] exp_p;
      if (ARESETN) begin
         exp_p = (S_AXI_BVALID && !prev_bv && b_q.size() > 0) ? b_q[0].pulse : 4'b0000;
         chk("reg_wr_pulse", 128'(reg_wr_pulse), 128'(exp_p));
         if (prev_bv && !prev_br) begin
            chk("bvalid_hold", 128'(S_AXI_BVALID), 128'(1));
            chk("bresp_hold", 128'(S_AXI_BRESP), 128'(prev_bresp));
         end
         if (prev_rv && !prev_rr) begin
            chk("rvalid_hold", 128'(S_AXI_RVALID), 128'(1));
            chk("rdata_hold", 128'(S_AXI_RDATA), 128'(prev_rdata));
            chk("rresp_hold", 128'(S_AXI_RRESP), 128'(prev_rresp));
         end
         if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (b_q.size() == 0) begin
               n_checks++;
               $display("FAIL b_unexpected: got BVALID=1 expected no response");
            end else begin
               be = b_q.pop_front();
               chk("bresp", 128'(S_AXI_BRESP), 128'(be.resp));
               chk("regs_after_b", {slv_reg3, slv_reg2, slv_reg1, slv_reg0}, be.regs);
            end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (r_q.size() == 0) begin
               n_checks++;
               $display("FAIL r_unexpected: got RVALID=1 expected no response");
            end else begin
               re = r_q.pop_front();
               chk("rdata", 128'(S_AXI_RDATA), 128'(re.data));
               chk("rresp", 128'(S_AXI_RRESP), 128'(re.resp));
            end
         end
      end
      prev_bv = S_AXI_BVALID; prev_br = S_AXI_BREADY; prev_bresp = S_AXI_BRESP;
      prev_rv = S_AXI_RVALID; prev_rr = S_AXI_RREADY;
      prev_rdata = S_AXI_RDATA; prev_rresp = S_AXI_RRESP;
   end

   initial begin
      logic [5:0] a;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;

      // Reset state
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(0));
      chk("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(0));
      chk("rst_resp_data", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 128'(0));
      chk("rst_regs", {slv_reg3, slv_reg2, slv_reg1, slv_reg0}, 128'(0));
      chk("rst_pulse", 128'(reg_wr_pulse), 128'(0));
      @(negedge ACLK);
      ARESETN = 1'b1;
      #1;
      chk("ready_before_edge", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(0));
      @(posedge ACLK); #1;
      chk("ready_after_edge", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

      // Basic write then read-back
      for (int i = 0; i < 4; i++) begin
         exp_write(6'(4 * i), 32'(i + 1), 4'hF);
         drive_write(6'(4 * i), 32'(i + 1), 4'hF, 0, 0, 1'b1);
      end
      for (int i = 0; i < 4; i++) begin
         exp_read(6'(4 * i));
         drive_read(6'(4 * i), 0, 1'b1);
      end

      // W leads AW by three cycles
      exp_write(6'h04, 32'hDEADBEEF, 4'hF);
      drive_write(6'h04, 32'hDEADBEEF, 4'hF, 3, 0, 1'b1);
      chk("slv_reg1_deadbeef", 128'(slv_reg1), 128'(32'hDEADBEEF));
      // AW leads W
      exp_write(6'h0C, 32'h0BADF00D, 4'hF);
      drive_write(6'h0C, 32'h0BADF00D, 4'hF, 0, 2, 1'b1);

      // Byte strobes
      exp_write(6'h08, 32'hFFFFFFFF, 4'hF);
      drive_write(6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b1);
      exp_write(6'h08, 32'h00000000, 4'b0101);
      drive_write(6'h08, 32'h00000000, 4'b0101, 0, 0, 1'b1);
      chk("slv_reg2_strb", 128'(slv_reg2), 128'(32'hFF00FF00));
      // Zero-strobe write still pulses
      exp_write(6'h00, 32'hFFFFFFFF, 4'b0000);
      drive_write(6'h00, 32'hFFFFFFFF, 4'b0000, 0, 0, 1'b1);

      // Backpressure on both channels
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      exp_write(6'h0C, 32'hA5A50001, 4'hF);
      exp_read(6'h08);
      fork
         drive_write(6'h0C, 32'hA5A50001, 4'hF, 0, 0, 1'b0);
         drive_read(6'h08, 0, 1'b0);
      join
      S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      repeat (10) begin
         @(negedge ACLK);
         chk("stall_awready", 128'(S_AXI_AWREADY), 128'(0));
         chk("stall_arready", 128'(S_AXI_ARREADY), 128'(0));
      end
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      drain();

      // Same-edge write commit and read of the same slot
      exp_read(6'h00);
      exp_write(6'h00, 32'h12345678, 4'hF);
      fork
         drive_write(6'h00, 32'h12345678, 4'hF, 0, 0, 1'b1);
         drive_read(6'h00, 0, 1'b1);
      join
      drain();

      // Unmapped slots
      exp_read(6'h20);
      drive_read(6'h20, 0, 1'b1);
      exp_write(6'h3C, 32'hCAFEF00D, 4'hF);
      drive_write(6'h3C, 32'hCAFEF00D, 4'hF, 0, 0, 1'b1);

      // Randomized traffic with random READY backpressure
      rand_bp = 1'b1;
      for (int t = 0; t < 80; t++) begin
         logic [31:0] d = $urandom;
         logic [3:0]  s = 4'($urandom_range(0, 15));
         int          op = $urandom_range(0, 2);
         a = 6'($urandom_range(0, 63));
         if (op == 0) begin
            exp_write(a, d, s);
            drive_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
         end else if (op == 1) begin
            exp_read(a);
            drive_read(a, $urandom_range(0, 2), 1'b1);
         end else begin
            logic [5:0] ra = 6'($urandom_range(0, 63));
            exp_read(ra);
            exp_write(a, d, s);
            fork
               drive_write(a, d, s, 0, 0, 1'b1);
               drive_read(ra, 0, 1'b1);
            join
         end
      end
      rand_bp = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      drain();

      // Reset while a response is pending
      exp_write(6'h00, 32'h5, 4'hF);
      drive_write(6'h00, 32'h5, 4'hF, 0, 0, 1'b1);
      S_AXI_BREADY = 1'b0;
      exp_write(6'h04, 32'h77, 4'hF);
      drive_write(6'h04, 32'h77, 4'hF, 0, 0, 1'b0);
      chk("pre_rst_reg0", 128'(slv_reg0), 128'(32'h5));
      #2 ARESETN = 1'b0;
      #1;
      chk("rst_bvalid_now", 128'(S_AXI_BVALID), 128'(0));
      chk("rst_reg0_now", 128'(slv_reg0), 128'(0));
      b_q.delete();
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      S_AXI_BREADY = 1'b1;
      repeat (10) begin
         @(negedge ACLK);
         chk("no_b_after_rst", 128'(S_AXI_BVALID), 128'(0));
      end
      @(posedge ACLK); #1;
      exp_read(6'h04);
      drive_read(6'h04, 0, 1'b1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
